mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage of the RV32I core; sits between the EX/MEM pipeline register and the register file write port.
- Executes loads and stores over a byte-wide, single-port RAM, one byte per cycle, stalling upstream while busy.
- Produces registered writeback signals (wb_we, wb_waddr, wb_wdata) that drive the register file's write port directly.

Parameters:
- XLEN, 32, data/address width in bits.
- OPW, 4, width of the mem_op encoding.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  EX/MEM holds a valid instruction
- in_mem_op  in  OPW  memory operation (package encoding)
- in_wreg  in  1  instruction writes rd
- in_wd  in  5  destination register index
- in_wdata  in  XLEN  ALU result (used when in_mem_op = MEM_NONE)
- in_addr  in  XLEN  effective address
- in_sdata  in  XLEN  store data (rs2)
- mem_a  out  XLEN  RAM byte address
- mem_dout  out  8  RAM write byte
- mem_wr  out  1  RAM write strobe
- mem_din  in  8  RAM read byte; valid one cycle after address
- stall_req  out  1  upstream must hold EX/MEM contents
- wb_we  out  1  register file write enable
- wb_waddr  out  5  register file write address
- wb_wdata  out  XLEN  register file write data

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- On reset, state = IDLE and cnt = 0; wb_we, wb_waddr, wb_wdata = 0.
- mem_a, mem_dout, mem_wr and stall_req are combinational from state and are 0 in IDLE with no memory op presented.
- States: IDLE, ACCESS (byte counter cnt), CAPTURE (loads only).
- Size N: LB/LBU/SB = 1; LH/LHU/SH = 2; LW/SW = 4.
- IDLE, in_valid, op = MEM_NONE:
  - Next edge: wb_we = in_wreg, wb_waddr = in_wd, wb_wdata = in_wdata.
  - stall_req = 0.
- IDLE, in_valid=0: next edge wb_we = 0 (bubble).
- IDLE, in_valid, memory op (accept cycle):
  - Latch op, wd, wreg, addr, sdata.
  - stall_req = 1; next state ACCESS, cnt = 0.
  - Next edge wb_we = 0.
- ACCESS:
  - mem_a = addr + cnt, modulo 2^XLEN (wraps; no alignment check, no exception).
  - Store: mem_wr = 1, mem_dout = sdata byte cnt (little-endian).
  - Load: mem_wr = 0, mem_dout = 0; when cnt >= 1, capture mem_din into byte cnt-1.
  - cnt increments each cycle.
  - Store, cnt = N-1: stall_req = 0; next state IDLE; next edge wb_we = 0.
  - Load, cnt = N-1: next state CAPTURE.
  - All other ACCESS cycles: stall_req = 1; wb_we held 0.
- CAPTURE:
  - Capture mem_din as byte N-1; stall_req = 0; mem outputs 0.
  - Next edge: wb_we = wreg, wb_waddr = wd.
  - wb_wdata = assembled value: sign-extended for LB/LH, zero-extended for LBU/LHU.
  - Next state IDLE.
- Latency, accept cycle = 0:
  - Store: access cycles 1..N; stall_req high in cycles 0..N-1.
  - Load: access cycles 1..N, capture cycle N+1; wb outputs valid in cycle N+2; stall_req high in cycles 0..N.
- Inputs are ignored whenever state != IDLE; upstream still presents the stalled op during the final cycle.
- Load with rd = x0: full access is performed; wb_we is raised as decoded, and the register file discards the x0 write.
- Reset mid-operation: at the edge, return to IDLE; the pending writeback is dropped, the partial store is not completed, and mem_wr = 0 from the next cycle.

Decomposition:
- Shared package (defines) holds:
  - mem_op codes: MEM_NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8.
  - State encodings.
  - Reuse of the existing ZeroWord, RegAddrBus and RegBus macros.
- One natural sub-module: load_extend (combinational; size and signedness plus raw bytes in, 32-bit result out).

Test Plan:
- MEM_NONE, in_wreg=1, in_wd=5, in_wdata=0x00001234 -> next cycle wb_we=1, wb_waddr=5, wb_wdata=0x00001234; stall_req never high.
- SW 0xDEADBEEF to 0x100 -> cycles 1-4:
  - mem_a = 0x100..0x103, mem_dout = EF, BE, AD, DE, mem_wr = 1.
  - stall_req high in cycles 0-3; wb_we stays 0.
- LW rd=7 from 0x100 -> cycle 6: wb_we=1, wb_waddr=7, wb_wdata=0xDEADBEEF; stall_req high in cycles 0-4.
- Sign/zero extension from the same memory:
  - LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE.
  - LH 0x102 -> 0xFFFFDEAD; LHU 0x102 -> 0x0000DEAD.
- Address wrap: SH 0x0000A55A at 0xFFFFFFFF -> byte 5A written at 0xFFFFFFFF, byte A5 at 0x00000000.
- Reset mid-operation: rst asserted in cycle 2 of an LW -> following cycle stall_req=0, mem_wr=0, wb_we=0, and no writeback occurs. A subsequent MEM_NONE op then writes back normally one cycle after presentation.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access stage: memory operation codes,
// FSM state encoding, register-file bus types and access-size helpers.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MEM_OPW    = 4;

    typedef logic [REG_BUS_W-1:0]  reg_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_bus_t ZERO_WORD = '0;

    typedef enum logic [MEM_OPW-1:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Byte counter within one access; a word needs four byte cycles.
    typedef logic [1:0] cnt_t;

    // Number of bytes moved by an operation; 0 for anything that is not a
    // load or store, so unknown encodings behave like MEM_NONE.
    function automatic logic [2:0] op_size(input mem_op_t op);
        case (op)
            LB, LBU, SB: op_size = 3'd1;
            LH, LHU, SH: op_size = 3'd2;
            LW, SW:      op_size = 3'd4;
            default:     op_size = 3'd0;
        endcase
    endfunction

    function automatic logic op_is_load(input mem_op_t op);
        op_is_load = (op inside {LB, LH, LW, LBU, LHU});
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        op_is_store = (op inside {SB, SH, SW});
    endfunction

    function automatic logic op_is_signed(input mem_op_t op);
        op_is_signed = (op inside {LB, LH});
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// -----------------------------------------------------------------------------
// mem_stage_load_extend
// Combinational sign/zero extension of an assembled little-endian load.
//   i_size   : bytes loaded (1, 2 or 4)
//   i_signed : 1 = sign-extend (LB/LH), 0 = zero-extend (LBU/LHU)
//   i_raw    : assembled bytes, byte 0 in bits [7:0]
//   o_data   : 32-bit register-file value
// -----------------------------------------------------------------------------
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic        i_signed,
    input  reg_bus_t    i_raw,
    output reg_bus_t    o_data
);

    always_comb begin
        case (i_size)
            3'd1:    o_data = {{24{i_signed & i_raw[7]}},  i_raw[7:0]};
            3'd2:    o_data = {{16{i_signed & i_raw[15]}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// RV32I memory-access pipeline stage. Moves one byte per cycle over a
// byte-wide single-port RAM, stalls upstream while busy, and drives the
// register-file write port from registers.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid .. in_sdata      : EX/MEM pipeline register contents
//   mem_a/mem_dout/mem_wr     : RAM address, write byte, write strobe
//   mem_din                   : RAM read byte, one cycle after its address
//   stall_req                 : upstream must hold EX/MEM contents
//   wb_we/wb_waddr/wb_wdata   : register-file write port
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [OPW-1:0]  in_mem_op,
    input  logic            in_wreg,
    input  logic [4:0]      in_wd,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_sdata,
    output logic [XLEN-1:0] mem_a,
    output logic [7:0]      mem_dout,
    output logic            mem_wr,
    input  logic [7:0]      mem_din,
    output logic            stall_req,
    output logic            wb_we,
    output logic [4:0]      wb_waddr,
    output logic [XLEN-1:0] wb_wdata
);

    state_t          r_state, w_state_nxt;
    cnt_t            r_cnt, w_cnt_nxt;
    mem_op_t         r_op;
    logic            r_wreg;
    logic [4:0]      r_wd;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_sdata;
    logic [23:0]     r_lbuf;     // load bytes 0..2; the last byte is taken live
    logic            r_wb_we;
    logic [4:0]      r_wb_waddr;
    logic [XLEN-1:0] r_wb_wdata;

    mem_op_t         w_in_op;
    logic            w_in_is_mem;
    logic            w_accept;
    logic [2:0]      w_size;
    cnt_t            w_last_cnt;
    logic            w_is_store;
    reg_bus_t        w_raw;
    reg_bus_t        w_ext;

    assign w_in_op     = mem_op_t'(in_mem_op);
    assign w_in_is_mem = op_is_load(w_in_op) | op_is_store(w_in_op);
    assign w_accept    = (r_state == IDLE) && in_valid && w_in_is_mem;
    assign w_size      = op_size(r_op);
    assign w_last_cnt  = cnt_t'(w_size - 3'd1);
    assign w_is_store  = op_is_store(r_op);

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        mem_a       = '0;
        mem_dout    = 8'h00;
        mem_wr      = 1'b0;
        stall_req   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    stall_req   = 1'b1;
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = '0;
                end
            end
            ACCESS: begin
                // Address wraps modulo 2^XLEN; no alignment check.
                mem_a     = r_addr + XLEN'(r_cnt);
                w_cnt_nxt = r_cnt + 2'd1;
                stall_req = 1'b1;
                if (w_is_store) begin
                    mem_wr   = 1'b1;
                    mem_dout = r_sdata[{r_cnt, 3'b000} +: 8];
                end
                if (r_cnt == w_last_cnt) begin
                    if (w_is_store) begin
                        // Final store byte: release upstream this cycle.
                        stall_req   = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Last load byte arrives during CAPTURE and is merged without a register.
    always_comb begin
        w_raw = {8'h00, r_lbuf};
        w_raw[{w_last_cnt, 3'b000} +: 8] = mem_din;
    end

    mem_stage_load_extend u_load_extend (
        .i_size   (w_size),
        .i_signed (op_is_signed(r_op)),
        .i_raw    (w_raw),
        .o_data   (w_ext)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= MEM_NONE;
            r_wreg     <= 1'b0;
            r_wd       <= '0;
            r_wb_we    <= 1'b0;
            r_wb_waddr <= '0;
            r_wb_wdata <= ZERO_WORD;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_in_op;
                        r_wreg  <= in_wreg;
                        r_wd    <= in_wd;
                        r_wb_we <= 1'b0;
                    end else if (in_valid) begin
                        r_wb_we    <= in_wreg;
                        r_wb_waddr <= in_wd;
                        r_wb_wdata <= in_wdata;
                    end else begin
                        r_wb_we <= 1'b0;
                    end
                end
                CAPTURE: begin
                    r_wb_we    <= r_wreg;
                    r_wb_waddr <= r_wd;
                    r_wb_wdata <= w_ext;
                end
                default: r_wb_we <= 1'b0;
            endcase
        end
    end

    // NOTE: address, store data and the load buffer carry no reset: each is
    // written before it is read, and the control path above gates their use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= in_addr;
            r_sdata <= in_sdata;
        end
        if (r_state == ACCESS && !w_is_store && r_cnt != 2'd0) begin
            r_lbuf[{r_cnt - 2'd1, 3'b000} +: 8] <= mem_din;
        end
    end

    assign wb_we    = r_wb_we;
    assign wb_waddr = r_wb_waddr;
    assign wb_wdata = r_wb_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage with a byte RAM model that
// returns read data one cycle after the address.
// -----------------------------------------------------------------------------
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_mem_op;
    logic        in_wreg;
    logic [4:0]  in_wd;
    logic [31:0] in_wdata;
    logic [31:0] in_addr;
    logic [31:0] in_sdata;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din = 8'h00;
    logic        stall_req;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram [logic [31:0]];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_mem_op (in_mem_op),
        .in_wreg   (in_wreg),
        .in_wd     (in_wd),
        .in_wdata  (in_wdata),
        .in_addr   (in_addr),
        .in_sdata  (in_sdata),
        .mem_a     (mem_a),
        .mem_dout  (mem_dout),
        .mem_wr    (mem_wr),
        .mem_din   (mem_din),
        .stall_req (stall_req),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata)
    );

    // Synchronous byte RAM: read data for the address seen at an edge is
    // available during the following cycle.
    always @(posedge clk) begin
        if (ram.exists(mem_a)) mem_din <= ram[mem_a];
        else                   mem_din <= 8'h00;
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return {24'h0, ram[a]};
        return 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic wreg, input logic [4:0] wd,
                           input logic [31:0] wdata, input logic [31:0] addr,
                           input logic [31:0] sdata);
        in_valid  = 1'b1;
        in_mem_op = op;
        in_wreg   = wreg;
        in_wd     = wd;
        in_wdata  = wdata;
        in_addr   = addr;
        in_sdata  = sdata;
    endtask

    task automatic drop();
        in_valid  = 1'b0;
        in_mem_op = MEM_NONE;
        in_wreg   = 1'b0;
        in_wd     = 5'd0;
        in_wdata  = 32'h0;
        in_addr   = 32'h0;
        in_sdata  = 32'h0;
    endtask

    // Store of n bytes; accept cycle 0, access cycles 1..n.
    task automatic do_store(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input int n);
        present(op, 1'b0, 5'd0, 32'h0, addr, sdata);
        #1;
        check("st_accept_stall", 32'(stall_req), 32'd1);
        check("st_accept_wr",    32'(mem_wr),    32'd0);
        for (int k = 1; k <= n; k++) begin
            next_cycle();
            #1;
            check("st_addr",  mem_a, addr + 32'(k - 1));
            check("st_dout",  32'(mem_dout), (sdata >> (8 * (k - 1))) & 32'hFF);
            check("st_wr",    32'(mem_wr), 32'd1);
            check("st_stall", 32'(stall_req), 32'(k < n));
            check("st_wb_we", 32'(wb_we), 32'd0);
        end
        next_cycle();
        drop();
        #1;
        check("st_done_wb_we", 32'(wb_we),     32'd0);
        check("st_done_wr",    32'(mem_wr),    32'd0);
        check("st_done_stall", 32'(stall_req), 32'd0);
    endtask

    // Load of n bytes; capture in cycle n+1, writeback visible in cycle n+2.
    task automatic do_load(input logic [3:0] op, input logic [4:0] wd, input logic [31:0] addr,
                           input int n, input logic [31:0] exp);
        present(op, 1'b1, wd, 32'h0, addr, 32'h0);
        #1;
        check("ld_accept_stall", 32'(stall_req), 32'd1);
        for (int k = 1; k <= n; k++) begin
            next_cycle();
            #1;
            check("ld_addr",  mem_a, addr + 32'(k - 1));
            check("ld_wr",    32'(mem_wr), 32'd0);
            check("ld_dout",  32'(mem_dout), 32'd0);
            check("ld_stall", 32'(stall_req), 32'd1);
            check("ld_wb_we", 32'(wb_we), 32'd0);
        end
        next_cycle();
        #1;
        check("ld_cap_stall", 32'(stall_req), 32'd0);
        check("ld_cap_addr",  mem_a, 32'h0);
        check("ld_cap_wb_we", 32'(wb_we), 32'd0);
        next_cycle();
        drop();
        #1;
        check("ld_wb_we",    32'(wb_we),    32'd1);
        check("ld_wb_waddr", 32'(wb_waddr), 32'(wd));
        check("ld_wb_wdata", wb_wdata,      exp);
        next_cycle();
        #1;
        check("ld_bubble_we", 32'(wb_we), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drop();
        repeat (3) next_cycle();
        check("rst_wb_we",    32'(wb_we),     32'd0);
        check("rst_wb_waddr", 32'(wb_waddr),  32'd0);
        check("rst_wb_wdata", wb_wdata,       32'd0);
        check("rst_stall",    32'(stall_req), 32'd0);
        check("rst_mem_wr",   32'(mem_wr),    32'd0);
        check("rst_mem_a",    mem_a,          32'd0);
        rst = 1'b0;
        next_cycle();

        // ALU pass-through
        present(MEM_NONE, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
        #1;
        check("none_stall", 32'(stall_req), 32'd0);
        next_cycle();
        drop();
        #1;
        check("none_wb_we",    32'(wb_we),     32'd1);
        check("none_wb_waddr", 32'(wb_waddr),  32'd5);
        check("none_wb_wdata", wb_wdata,       32'h0000_1234);
        check("none_stall2",   32'(stall_req), 32'd0);
        next_cycle();
        check("bubble_wb_we",  32'(wb_we), 32'd0);

        // MEM_NONE with no destination write
        present(MEM_NONE, 1'b0, 5'd6, 32'h5555_AAAA, 32'h0, 32'h0);
        next_cycle();
        drop();
        #1;
        check("none_nowreg_we", 32'(wb_we), 32'd0);
        next_cycle();

        // Word store, then loads of every width from the same bytes
        do_store(SW, 32'h0000_0100, 32'hDEAD_BEEF, 4);
        check("ram_100", ram_rd(32'h100), 32'hEF);
        check("ram_103", ram_rd(32'h103), 32'hDE);
        do_load(LW,  5'd7, 32'h0000_0100, 4, 32'hDEAD_BEEF);
        do_load(LB,  5'd8, 32'h0000_0103, 1, 32'hFFFF_FFDE);
        do_load(LBU, 5'd8, 32'h0000_0103, 1, 32'h0000_00DE);
        do_load(LH,  5'd9, 32'h0000_0102, 2, 32'hFFFF_DEAD);
        do_load(LHU, 5'd9, 32'h0000_0102, 2, 32'h0000_DEAD);
        do_load(LH,  5'd9, 32'h0000_0100, 2, 32'hFFFF_BEEF);
        do_load(LW,  5'd0, 32'h0000_0100, 4, 32'hDEAD_BEEF);

        // Byte store and positive-byte sign extension
        do_store(SB, 32'h0000_0200, 32'hFFFF_FF80, 1);
        check("ram_200", ram_rd(32'h200), 32'h80);
        check("ram_201", ram_rd(32'h201), 32'h00);
        do_load(LB, 5'd10, 32'h0000_0200, 1, 32'hFFFF_FF80);
        do_store(SB, 32'h0000_0201, 32'h0000_007F, 1);
        do_load(LH, 5'd11, 32'h0000_0200, 2, 32'h0000_7F80);

        // Address wrap across 2^32
        do_store(SH, 32'hFFFF_FFFF, 32'h0000_A55A, 2);
        check("ram_wrap_hi", ram_rd(32'hFFFF_FFFF), 32'h5A);
        check("ram_wrap_lo", ram_rd(32'h0000_0000), 32'hA5);
        do_load(LHU, 5'd12, 32'hFFFF_FFFF, 2, 32'h0000_A55A);
        do_load(LH,  5'd12, 32'hFFFF_FFFF, 2, 32'hFFFF_A55A);

        // Reset in cycle 2 of a word load
        present(LW, 1'b1, 5'd9, 32'h0, 32'h0000_0100, 32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        drop();
        next_cycle();
        rst = 1'b0;
        #1;
        check("rstld_stall", 32'(stall_req), 32'd0);
        check("rstld_wr",    32'(mem_wr),    32'd0);
        check("rstld_wb_we", 32'(wb_we),     32'd0);
        check("rstld_addr",  mem_a,          32'd0);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            check("rstld_no_wb", 32'(wb_we), 32'd0);
        end
        present(MEM_NONE, 1'b1, 5'd3, 32'hCAFE_F00D, 32'h0, 32'h0);
        #1;
        check("rstld_none_stall", 32'(stall_req), 32'd0);
        next_cycle();
        drop();
        #1;
        check("rstld_none_we",    32'(wb_we),    32'd1);
        check("rstld_none_waddr", 32'(wb_waddr), 32'd3);
        check("rstld_none_wdata", wb_wdata,      32'hCAFE_F00D);
        next_cycle();

        // Reset in cycle 2 of a word store: bytes 2 and 3 never written
        present(SW, 1'b0, 5'd0, 32'h0, 32'h0000_0300, 32'h1122_3344);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        drop();
        next_cycle();
        rst = 1'b0;
        #1;
        check("rstst_wr",    32'(mem_wr),    32'd0);
        check("rstst_stall", 32'(stall_req), 32'd0);
        repeat (3) next_cycle();
        check("rstst_ram_300", ram_rd(32'h300), 32'h44);
        check("rstst_ram_301", ram_rd(32'h301), 32'h33);
        check("rstst_ram_302", ram_rd(32'h302), 32'h00);
        check("rstst_ram_303", ram_rd(32'h303), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
